// File: rtl/flit_receiver.sv
// flit_receiver: round-robin, packet-locked arbiter over the input channels
// feeding a show-ahead flit FIFO for the PGNoC switch transceiver.
module flit_receiver #(
    parameter  int DATA_SIZE  = 32,
    parameter  int ADDR_SIZE  = 4,
    parameter  int PORTS_NUM  = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int BUS_SIZE   = DATA_SIZE + ADDR_SIZE + 1,
    localparam int NCH        = PORTS_NUM + 1,
    localparam int FW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          wr_ready_in,
    input  logic [BUS_SIZE*NCH-1:0] data_i,
    input  logic                    mem_readed,
    output logic [NCH-1:0]          r_ready_out,
    output logic                    mem_empty,
    output logic [BUS_SIZE-1:0]     data_o,
    output logic [FW-1:0]           fill_level
);
    localparam int AW = FW - 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_lock_ch;
    logic [CW-1:0]       w_lock_nxt;
    logic [CW-1:0]       r_rr_ptr;
    logic [CW-1:0]       w_rr_nxt;

    logic [NCH-1:0]      r_ready;
    logic [BUS_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [FW-1:0]       r_fill;
    logic                r_empty;
    logic [BUS_SIZE-1:0] r_head;

    logic [BUS_SIZE-1:0] w_ch_flit [NCH];
    logic                w_full;
    logic [NCH-1:0]      w_elig;
    logic                w_gnt_vld;
    logic [CW-1:0]       w_gnt_ch;
    logic [CW:0]         w_sum;
    logic [CW-1:0]       w_idx;
    logic [BUS_SIZE-1:0] w_flit;
    logic                w_tail;
    logic [CW-1:0]       w_ch_inc;
    logic                w_push;
    logic                w_pop;
    logic [FW-1:0]       w_fill_nxt;
    logic [AW-1:0]       w_rd_nxt;
    logic [BUS_SIZE-1:0] w_head_nxt;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_ch_flit[k] = data_i[k*BUS_SIZE +: BUS_SIZE];
        end
    end

    // A channel whose accept pulse is still high is mid-handshake.
    assign w_full = (r_fill == FW'(FIFO_DEPTH));
    assign w_elig = wr_ready_in & ~r_ready & {NCH{~w_full}};

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_sum     = '0;
        w_idx     = '0;
        unique case (r_state)
            ST_IDLE: begin
                for (int k = 0; k < NCH; k++) begin
                    w_sum = {1'b0, r_rr_ptr} + (CW+1)'(k);
                    if (w_sum >= (CW+1)'(NCH)) begin
                        w_sum = w_sum - (CW+1)'(NCH);
                    end
                    w_idx = w_sum[CW-1:0];
                    if (!w_gnt_vld && w_elig[w_idx]) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_ch  = w_idx;
                    end
                end
            end
            ST_LOCKED: begin
                w_gnt_vld = w_elig[r_lock_ch];
                w_gnt_ch  = r_lock_ch;
            end
        endcase
    end

    assign w_flit   = w_ch_flit[w_gnt_ch];
    assign w_tail   = w_flit[ADDR_SIZE];
    assign w_ch_inc = (w_gnt_ch == CW'(NCH - 1)) ? '0 : w_gnt_ch + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_ch;
        w_rr_nxt    = r_rr_ptr;
        if (w_gnt_vld) begin
            if (w_tail) begin
                w_state_nxt = ST_IDLE;
                w_rr_nxt    = w_ch_inc;
            end else begin
                w_state_nxt = ST_LOCKED;
                w_lock_nxt  = w_gnt_ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_ch <= w_lock_nxt;
            r_rr_ptr  <= w_rr_nxt;
        end
    end

    assign w_push     = w_gnt_vld;
    assign w_pop      = mem_readed & ~r_empty;
    assign w_fill_nxt = r_fill + FW'(w_push) - FW'(w_pop);
    assign w_rd_nxt   = w_pop ? r_rptr + 1'b1 : r_rptr;

    // The new head may be the flit being written this very cycle.
    always_comb begin
        w_head_nxt = r_mem[w_rd_nxt];
        if (w_fill_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_push && (w_rd_nxt == r_wptr)) begin
            w_head_nxt = w_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_flit;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_fill  <= '0;
            r_empty <= 1'b1;
            r_head  <= '0;
        end else begin
            r_ready <= w_push ? (NCH'(1) << w_gnt_ch) : '0;
            r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr  <= w_rd_nxt;
            r_fill  <= w_fill_nxt;
            r_empty <= (w_fill_nxt == '0);
            r_head  <= w_head_nxt;
        end
    end

    assign r_ready_out = r_ready;
    assign mem_empty   = r_empty;
    assign data_o      = r_head;
    assign fill_level  = r_fill;

endmodule
